// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Holds default widths, the reset PC and the 2-bit FSM state encodings.
// Imported by the top level and the program counter.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned INST_W_DEF   = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: absolute set (redirect), increment (load) or hold.
// Latency: new PC visible the cycle after set/inc; wrap pulses the cycle after a 15->0 step.
// Backpressure: none here; the caller only asserts inc when a fetch is really taken.
module program_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] PC_MAX = '1;
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  // Set has priority over increment; wrap only flags a sequential step past the top,
  // so a redirect that lands on address 0 never pulses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= PC_RST;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (set) begin
        pc <= set_pc;
      end else if (inc) begin
        pc   <= pc + ADDR_W'(1);
        wrap <= (pc == PC_MAX);
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, drives the ROM address, presents fetched words to decode.
// Latency: run sampled in IDLE -> first load one edge later; then one instruction per cycle.
// Backpressure: ir/ir_pc/PC hold while ir_valid & !ir_ready; redirect costs exactly one bubble.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INST_W   = INST_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted,
  output logic              wrap
);

  fsm_state_t        state;
  fsm_state_t        next_state;
  logic              do_load;
  logic              do_set;
  logic              ir_valid_next;
  logic [ADDR_W-1:0] pc;

  program_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .set   (do_set),
    .set_pc(redirect_pc),
    .inc   (do_load),
    .pc    (pc),
    .wrap  (wrap)
  );

  assign rom_addr = pc;
  assign halted   = (state == ST_HALTED);

  // Next state and per-cycle action; priority in FETCH is halt > redirect > load > drain.
  always_comb begin
    next_state    = state;
    do_load       = 1'b0;
    do_set        = 1'b0;
    ir_valid_next = ir_valid;
    case (state)
      ST_IDLE: begin
        if (ir_valid && ir_ready) ir_valid_next = 1'b0;
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt) begin
          next_state    = ST_HALTED;
          ir_valid_next = 1'b0;
        end else if (redirect_valid) begin
          // Any unconsumed word is a wrong-path fetch: drop it.
          do_set        = 1'b1;
          ir_valid_next = 1'b0;
        end else if (!run) begin
          next_state = ST_IDLE;
          if (ir_valid && ir_ready) ir_valid_next = 1'b0;
        end else if (!ir_valid || ir_ready) begin
          do_load       = 1'b1;
          ir_valid_next = 1'b1;
        end
      end
      ST_HALTED: begin
        ir_valid_next = 1'b0;
      end
      default: begin
        next_state    = ST_IDLE;
        ir_valid_next = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Instruction register: captures the ROM word and its address on each load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      ir_valid <= ir_valid_next;
      if (do_load) begin
        ir    <= rom_data;
        ir_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a ROM array and a transaction-level model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ir;
  logic [3:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_pc = 4'd0;
  logic        halt = 1'b0;
  logic        halted;
  logic        wrap;

  logic [15:0] rom [16];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: mode 0 idle, 1 fetching, 2 halted
  int          m_mode;
  int          m_pc;
  logic [15:0] m_ir;
  int          m_ir_pc;
  bit          m_v;
  bit          m_wrap;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .halted        (halted),
    .wrap          (wrap)
  );

  task automatic model_step();
    bit wrap_n;
    wrap_n = 1'b0;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_ir = 16'h0; m_ir_pc = 0; m_v = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (m_v && ir_ready) m_v = 1'b0;
          if (run) m_mode = 1;
        end
        1: begin
          if (halt) begin
            m_mode = 2; m_v = 1'b0;
          end else if (redirect_valid) begin
            m_pc = int'(redirect_pc); m_v = 1'b0;
          end else if (!run) begin
            m_mode = 0;
            if (m_v && ir_ready) m_v = 1'b0;
          end else if (!m_v || ir_ready) begin
            m_ir = rom[m_pc]; m_ir_pc = m_pc; m_v = 1'b1;
            if (m_pc == 15) wrap_n = 1'b1;
            m_pc = (m_pc + 1) % 16;
          end
        end
        default: ;
      endcase
    end
    m_wrap = wrap_n;
  endtask

  function automatic logic [26:0] exp_vec();
    return {m_ir, 4'(m_ir_pc), m_v, (m_mode == 2), m_wrap, 4'(m_pc)};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {ir, ir_pc, ir_valid, halted, wrap, rom_addr};
  endfunction

  // Advance one clock; inputs are stable at the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; ir_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    step(); step();
    tests_run++;
    if (dut_vec() !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h required %h", dut_vec(), 27'd0);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL reset_idle_hold: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_run();
    logic [15:0] exp_ir [3];
    exp_ir[0] = 16'hAE01; exp_ir[1] = 16'hFE00; exp_ir[2] = 16'hBE01;
    run = 1'b1; ir_ready = 1'b1;
    step();
    tests_run++;
    if (ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_start_latency: ir_valid got %b required 0", ir_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (ir !== exp_ir[i] || ir_pc !== 4'(i) || ir_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL run_seq%0d: ir=%h pc=%0d v=%b required ir=%h pc=%0d v=1",
                 i, ir, ir_pc, ir_valid, exp_ir[i], i);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    while (ir_pc !== 4'd4 && n < 40) begin step(); n++; end
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (ir !== 16'hAE01 || ir_pc !== 4'd4 || ir_valid !== 1'b1 || rom_addr !== 4'd5
          || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: ir=%h ir_pc=%0d v=%b pc=%0d required ir=ae01 ir_pc=4 v=1 pc=5",
                 i, ir, ir_pc, ir_valid, rom_addr);
      end
    end
    ir_ready = 1'b1;
    step();
    tests_run++;
    if (ir_pc !== 4'd5 || ir_valid !== 1'b1 || ir !== rom[5]) begin
      tests_failed++;
      $display("FAIL stall_resume: ir_pc=%0d v=%b required ir_pc=5 v=1", ir_pc, ir_valid);
    end
  endtask

  task automatic test_wrap();
    int n;
    int pulses;
    n = 0; pulses = 0;
    while (ir_pc !== 4'd15 && n < 40) begin
      step(); n++;
      if (wrap === 1'b1) pulses++;
    end
    tests_run++;
    if (ir !== 16'hFE00 || ir_pc !== 4'd15 || wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_at15: ir=%h ir_pc=%0d wrap=%b required ir=fe00 ir_pc=15 wrap=1",
               ir, ir_pc, wrap);
    end
    step();
    if (wrap === 1'b1) pulses++;
    tests_run++;
    if (ir !== 16'hAE01 || ir_pc !== 4'd0 || wrap !== 1'b0 || pulses != 1) begin
      tests_failed++;
      $display("FAIL wrap_next: ir=%h ir_pc=%0d wrap=%b pulses=%0d required ir=ae01 ir_pc=0 wrap=0 pulses=1",
               ir, ir_pc, wrap, pulses);
    end
  endtask

  task automatic test_redirect();
    int n;
    n = 0;
    while (ir_pc !== 4'd3 && n < 40) begin step(); n++; end
    redirect_valid = 1'b1; redirect_pc = 4'd10;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (ir_valid !== 1'b0 || rom_addr !== 4'd10) begin
      tests_failed++;
      $display("FAIL redirect_bubble: v=%b pc=%0d required v=0 pc=10", ir_valid, rom_addr);
    end
    step();
    tests_run++;
    if (ir !== 16'h2FC1 || ir_pc !== 4'd10 || ir_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL redirect_target: ir=%h ir_pc=%0d v=%b required ir=2fc1 ir_pc=10 v=1",
               ir, ir_pc, ir_valid);
    end
  endtask

  task automatic test_run_drop();
    logic [15:0] held_ir;
    logic [3:0]  held_pc;
    logic [3:0]  held_addr;
    held_ir = ir; held_pc = ir_pc; held_addr = rom_addr;
    run = 1'b0; ir_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (ir !== held_ir || ir_pc !== held_pc || ir_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL rundrop_hold%0d: ir=%h ir_pc=%0d v=%b required ir=%h ir_pc=%0d v=1",
                 i, ir, ir_pc, ir_valid, held_ir, held_pc);
      end
    end
    ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (ir_valid !== 1'b0 || rom_addr !== held_addr || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL rundrop_drain%0d: v=%b pc=%0d required v=0 pc=%0d",
                 i, ir_valid, rom_addr, held_addr);
      end
    end
  endtask

  task automatic test_halt_vs_redirect();
    logic [3:0] pc_at_halt;
    run = 1'b1; ir_ready = 1'b1;
    step(); step(); step();
    pc_at_halt = rom_addr;
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = pc_at_halt ^ 4'h7;
    step();
    halt = 1'b0; redirect_valid = 1'b0;
    tests_run++;
    if (halted !== 1'b1 || ir_valid !== 1'b0 || rom_addr !== pc_at_halt) begin
      tests_failed++;
      $display("FAIL halt_entry: halted=%b v=%b pc=%0d required halted=1 v=0 pc=%0d",
               halted, ir_valid, rom_addr, pc_at_halt);
    end
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom); ir_ready = 1'($urandom);
      redirect_valid = 1'($urandom); redirect_pc = 4'($urandom); halt = 1'($urandom);
      step();
      tests_run++;
      if (halted !== 1'b1 || ir_valid !== 1'b0 || rom_addr !== pc_at_halt || wrap !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_sticky%0d: halted=%b v=%b pc=%0d required halted=1 v=0 pc=%0d",
                 i, halted, ir_valid, rom_addr, pc_at_halt);
      end
    end
    halt = 1'b0; redirect_valid = 1'b0; run = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (halted !== 1'b0 || rom_addr !== 4'd0 || ir_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL halt_reset: halted=%b pc=%0d v=%b required halted=0 pc=0 v=0",
               halted, rom_addr, ir_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset          = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
      run            = ($urandom_range(0, 9) != 0);
      ir_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      halt           = ($urandom_range(0, 199) == 0);
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: {ir,ir_pc,v,halted,wrap,pc} got %h required %h",
                 i, dut_vec(), exp_vec());
      end
    end
    reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    rom[0]  = 16'hAE01; rom[1] = 16'hFE00; rom[2] = 16'hBE01;
    rom[4]  = 16'hAE01; rom[10] = 16'h2FC1; rom[15] = 16'hFE00;
    m_mode = 0; m_pc = 0; m_ir = 16'h0; m_ir_pc = 0; m_v = 1'b0; m_wrap = 1'b0;

    test_reset();
    test_run();
    test_stall();
    test_wrap();
    test_redirect();
    test_run_drop();
    test_halt_vs_redirect();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
